// File: rtl/theta_differentiator.sv
// rtl/theta_differentiator.sv - converts normalized absolute angles into wrapped per-sample increments
// Optional output clamp to +/-MAX_DELTA_URAD is built only when THETA_DIFF_SAT_EN is defined.
module theta_differentiator #(
  parameter longint TWO_PI_URAD    = 64'sd6283185,
  parameter longint PI_URAD        = 64'sd3141592,
  parameter longint MAX_DELTA_URAD = 64'sd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] theta_in,
  output logic [63:0] delta_theta,
  output logic        done,
  output logic        sat
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SUBTRAI   = 2'd1;
  localparam logic [1:0] ST_NORMALIZA = 2'd2;
  localparam logic [1:0] ST_FIM       = 2'd3;

  localparam logic signed [65:0] LP_TWO_PI = 66'(TWO_PI_URAD);
  localparam logic signed [65:0] LP_PI     = 66'(PI_URAD);

  logic [1:0]         r_state;
  logic [63:0]        r_theta_cur;
  logic [63:0]        r_theta_prev;
  logic signed [64:0] r_diff;
  logic               r_primed;
  logic [63:0]        r_delta;
  logic               r_sat;

  logic signed [65:0] w_diff_ext;
  logic signed [65:0] w_wrapped;
  logic [63:0]        w_delta_next;
  logic               w_sat_next;

  assign w_diff_ext = {r_diff[64], r_diff};

  // Single wrap correction: out-of-range inputs may still land outside [-PI, PI).
  always_comb begin
    w_wrapped = w_diff_ext;
    if (w_diff_ext >= LP_PI) begin
      w_wrapped = w_diff_ext - LP_TWO_PI;
    end else if (w_diff_ext < -LP_PI) begin
      w_wrapped = w_diff_ext + LP_TWO_PI;
    end
  end

`ifdef THETA_DIFF_SAT_EN
  localparam logic signed [65:0] LP_MAX = 66'(MAX_DELTA_URAD);

  always_comb begin
    w_delta_next = w_wrapped[63:0];
    w_sat_next   = 1'b0;
    if (w_wrapped > LP_MAX) begin
      w_delta_next = LP_MAX[63:0];
      w_sat_next   = 1'b1;
    end else if (w_wrapped < -LP_MAX) begin
      w_delta_next = 64'(-MAX_DELTA_URAD);
      w_sat_next   = 1'b1;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi  = ^w_wrapped[65:64];
  assign w_delta_next = w_wrapped[63:0];
  assign w_sat_next   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_theta_cur  <= '0;
      r_theta_prev <= '0;
      r_diff       <= '0;
      r_primed     <= 1'b0;
      r_delta      <= '0;
      r_sat        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_theta_cur <= theta_in;
            r_state     <= ST_SUBTRAI;
          end
        end
        ST_SUBTRAI: begin
          r_diff  <= $signed({r_theta_cur[63], r_theta_cur}) -
                     $signed({r_theta_prev[63], r_theta_prev});
          r_state <= ST_NORMALIZA;
        end
        ST_NORMALIZA: begin
          // The first sample after reset only primes the history.
          if (r_primed) begin
            r_delta <= w_delta_next;
            r_sat   <= w_sat_next;
          end else begin
            r_delta <= '0;
            r_sat   <= 1'b0;
          end
          r_theta_prev <= r_theta_cur;
          r_primed     <= 1'b1;
          r_state      <= ST_FIM;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign delta_theta = r_delta;
  assign sat         = r_sat;
  assign done        = (r_state == ST_FIM);

endmodule

// File: tb/tb_theta_differentiator.sv
// tb/tb_theta_differentiator.sv - randomized self-checking bench for theta_differentiator
// Follows THETA_DIFF_SAT_EN the same way the design does.
module tb_theta_differentiator;

  localparam longint TWO_PI = 6283185;
  localparam longint PI     = 3141592;
  localparam longint MAXD   = 500000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] theta_in = '0;
  logic [63:0] delta_theta;
  logic        done;
  logic        sat;

  int checks = 0;
  int errors = 0;

  longint m_prev = 0;
  bit     m_primed = 1'b0;

  theta_differentiator dut (
    .clk(clk), .reset(reset), .start(start), .theta_in(theta_in),
    .delta_theta(delta_theta), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Reference: difference from previous sample, one wrap, optional clamp.
  task automatic model_step(input longint cur, output longint d, output bit s);
    longint diff;
    diff = cur - m_prev;
    if (diff >= PI) diff = diff - TWO_PI;
    else if (diff < -PI) diff = diff + TWO_PI;
    s = 1'b0;
`ifdef THETA_DIFF_SAT_EN
    if (diff > MAXD) begin diff = MAXD; s = 1'b1; end
    else if (diff < -MAXD) begin diff = -MAXD; s = 1'b1; end
`endif
    if (!m_primed) begin diff = 0; s = 1'b0; end
    d = diff;
    m_prev = cur;
    m_primed = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    m_prev = 0;
    m_primed = 1'b0;
  endtask

  task automatic do_op(input longint th, input string tag);
    longint d;
    bit s;
    @(negedge clk); start = 1'b1; theta_in = th;
    @(negedge clk); start = 1'b0; theta_in = {$urandom, $urandom};
    check({tag, "_done_c1"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, "_done_c2"}, 64'(done), 64'd0);
    @(negedge clk);
    model_step(th, d, s);
    check({tag, "_done_c3"}, 64'(done), 64'd1);
    check({tag, "_delta"}, delta_theta, d);
    check({tag, "_sat"}, 64'(sat), 64'(s));
    @(negedge clk);
    check({tag, "_done_off"}, 64'(done), 64'd0);
    check({tag, "_hold"}, delta_theta, d);
  endtask

  initial begin
    longint d;
    bit s;
    longint th;
    logic [15:0] mask_got;
    logic [15:0] mask_exp;
    int next_free;

    do_reset();
    @(negedge clk);
    check("rst_delta", delta_theta, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);

    do_op(1000000, "prime");
    do_op(1250000, "plus");
    do_op(900000, "minus");
    do_op(6200000, "pre_wrap");
    do_op(100000, "wrap_up");
    do_op(6200000, "wrap_dn");

    do_reset();
    do_op(0, "b_prime0");
    do_op(3141592, "b_pi");
    do_reset();
    do_op(0, "b_prime1");
    do_op(3141591, "b_pi_m1");

    do_reset();
    do_op(0, "s_prime");
    do_op(800000, "s_big");
    do_op(700000, "s_small");

    // start held high: accepted once per four cycles
    do_op(2000000, "h_pre");
    th = 3500000;
    mask_got = '0;
    mask_exp = '0;
    next_free = 0;
    for (int e = 0; e < 10; e++) begin
      if (e >= next_free) begin
        mask_exp[e + 2] = 1'b1;
        next_free = e + 4;
      end
    end
    @(negedge clk); start = 1'b1; theta_in = th;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 9) start = 1'b0;
      mask_got[i] = done;
      if (done) begin
        model_step(th, d, s);
        check("h_delta", delta_theta, d);
      end
    end
    check("h_done_mask", 64'(mask_got), 64'(mask_exp));

    // reset while in NORMALIZA aborts the operation
    do_op(1000000, "a_pre");
    do_op(1250000, "a_pre2");
    @(negedge clk); start = 1'b1; theta_in = 2000000;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_prev = 0;
    m_primed = 1'b0;
    mask_got = '0;
    for (int i = 0; i < 5; i++) begin
      mask_got[i] = done;
      @(negedge clk);
    end
    check("a_no_done", 64'(mask_got), 64'd0);
    check("a_delta0", delta_theta, 64'd0);
    do_op(3000000, "a_reprime");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: th = -longint'($urandom_range(1, 1000000));
        1: th = TWO_PI + longint'($urandom_range(0, 1000000));
        default: th = longint'($urandom_range(0, 6283184));
      endcase
      do_op(th, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
